// File: rtl/sumador_serie_if.sv
// sumador_serie_if: operand/result bundle for the serial adder/subtractor.
//   start       request, sampled only while busy=0
//   A, B        WIDTH-bit operands
//   Ci          carry-in (add) / borrow-in (subtract)
//   Op          0 = add, 1 = subtract
//   busy        operation in progress
//   done        one-cycle pulse when S/C/V have just been loaded
//   S, C, V     result, carry-out of the MSB, two's-complement overflow
// master drives the request side; slave is the adder.
interface sumador_serie_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             Op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;

  modport master (
    output start, A, B, Ci, Op,
    input  busy, done, S, C, V
  );

  modport slave (
    input  start, A, B, Ci, Op,
    output busy, done, S, C, V
  );
endinterface

// File: rtl/sumador_serie.sv
// sumador_serie: multi-cycle adder/subtractor processing DIGIT bits per clock.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sumador_serie_if slave: start/A/B/Ci/Op in, busy/done/S/C/V out
// An accepted start captures the operands; WIDTH/DIGIT cycles later S/C/V are
// loaded together and done pulses for one cycle.
module sumador_serie #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic            clk,
  input logic            rst_n,
  sumador_serie_if.slave bus
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("sumador_serie: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
    end
  endgenerate

  logic [0:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  // a_q doubles as the accumulator: operand bits shift out at the bottom while
  // finished sum slices shift in at the top, so after N slices it holds S.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtract
  logic             carry_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             v_q;

  logic [DIGIT:0]   slice_sum;
  logic             carry_msb;
  logic [WIDTH-1:0] a_shift;

  always_comb begin
    slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} +
                {{DIGIT{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from its sum bit; on the last slice
    // this is the carry into bit WIDTH-1.
    carry_msb = slice_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    a_shift   = (a_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.Op ? ~bus.B : bus.B;
            carry_q <= bus.Op ^ bus.Ci;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_shift;
          b_q     <= b_q >> DIGIT;
          carry_q <= slice_sum[DIGIT];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            s_q     <= a_shift;
            c_q     <= slice_sum[DIGIT];
            v_q     <= carry_msb ^ slice_sum[DIGIT];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.C    = c_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_sumador_serie.sv
// tb_sumador_serie: directed and random checks of sumador_serie, WIDTH=8,
// DIGIT in {1, 2, 4, 8}, one instance per DIGIT sharing clock/reset/operands.
module tb_sumador_serie;

  logic       clk;
  logic       rst_n;
  logic [3:0] start_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic       ci_r;
  logic       op_r;

  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [3:0] c_w;
  logic [3:0] v_w;
  logic [7:0] s_w [4];

  int checks;
  int errors;

  sumador_serie_if #(.WIDTH(8)) if1 ();
  sumador_serie_if #(.WIDTH(8)) if2 ();
  sumador_serie_if #(.WIDTH(8)) if4 ();
  sumador_serie_if #(.WIDTH(8)) if8 ();

  assign if1.start = start_r[0];
  assign if2.start = start_r[1];
  assign if4.start = start_r[2];
  assign if8.start = start_r[3];
  assign if1.A = a_r;  assign if1.B = b_r;  assign if1.Ci = ci_r;  assign if1.Op = op_r;
  assign if2.A = a_r;  assign if2.B = b_r;  assign if2.Ci = ci_r;  assign if2.Op = op_r;
  assign if4.A = a_r;  assign if4.B = b_r;  assign if4.Ci = ci_r;  assign if4.Op = op_r;
  assign if8.A = a_r;  assign if8.B = b_r;  assign if8.Ci = ci_r;  assign if8.Op = op_r;

  assign busy_w = {if8.busy, if4.busy, if2.busy, if1.busy};
  assign done_w = {if8.done, if4.done, if2.done, if1.done};
  assign c_w    = {if8.C, if4.C, if2.C, if1.C};
  assign v_w    = {if8.V, if4.V, if2.V, if1.V};
  assign s_w[0] = if1.S;
  assign s_w[1] = if2.S;
  assign s_w[2] = if4.S;
  assign s_w[3] = if8.S;

  sumador_serie #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sumador_serie #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  sumador_serie #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  sumador_serie #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       op;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs [8];
  int   digit_of [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model from plain integer arithmetic.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic op, output logic [7:0] s, output logic c, output logic v);
    int ua, ub, sa, sb, ic, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ic = ci ? 1 : 0;
    if (op) begin
      r  = ua - ub - ic;
      sr = sa - sb - ic;
      c  = (r >= 0);
    end else begin
      r  = ua + ub + ic;
      sr = sa + sb + ic;
      c  = (r > 255);
    end
    s = r[7:0];
    v = (sr > 127) || (sr < -128);
  endtask

  // Starts an operation on instance idx from just after an edge and checks
  // latency, busy duration and result.
  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic op, input logic [7:0] es,
                        input logic ec, input logic ev);
    int cyc;
    int busy_n;
    a_r = a; b_r = b; ci_r = ci; op_r = op;
    start_r[idx] = 1'b1;
    @(posedge clk); #1;
    start_r[idx] = 1'b0;
    cyc = 0;
    busy_n = 0;
    while (!done_w[idx] && cyc < 20) begin
      if (busy_w[idx]) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("latency d%0d", digit_of[idx]), cyc, 8 / digit_of[idx]);
    check($sformatf("busy_cycles d%0d", digit_of[idx]), busy_n, 8 / digit_of[idx]);
    check($sformatf("busy_at_done d%0d", digit_of[idx]), int'(busy_w[idx]), 0);
    check($sformatf("S d%0d %0h op%0d %0h", digit_of[idx], a, op, b), int'(s_w[idx]), int'(es));
    check($sformatf("C d%0d %0h op%0d %0h", digit_of[idx], a, op, b), int'(c_w[idx]), int'(ec));
    check($sformatf("V d%0d %0h op%0d %0h", digit_of[idx], a, op, b), int'(v_w[idx]), int'(ev));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [7:0] es, ra, rb;
    logic       ec, ev, rci, rop;
    int         ndone, first;

    checks = 0;
    errors = 0;
    digit_of[0] = 1; digit_of[1] = 2; digit_of[2] = 4; digit_of[3] = 8;

    vecs[0] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, op: 1'b0, s: 8'h00, c: 1'b1, v: 1'b0};
    vecs[1] = '{a: 8'h05, b: 8'h07, ci: 1'b0, op: 1'b1, s: 8'hFE, c: 1'b0, v: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, ci: 1'b0, op: 1'b1, s: 8'h7F, c: 1'b1, v: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'h01, ci: 1'b1, op: 1'b0, s: 8'h81, c: 1'b0, v: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h80, ci: 1'b0, op: 1'b0, s: 8'h00, c: 1'b1, v: 1'b1};
    vecs[5] = '{a: 8'h03, b: 8'h04, ci: 1'b0, op: 1'b0, s: 8'h07, c: 1'b0, v: 1'b0};
    vecs[6] = '{a: 8'h10, b: 8'h10, ci: 1'b1, op: 1'b1, s: 8'hFF, c: 1'b0, v: 1'b0};
    vecs[7] = '{a: 8'h0F, b: 8'h01, ci: 1'b0, op: 1'b0, s: 8'h10, c: 1'b0, v: 1'b0};

    rst_n = 1'b0;
    start_r = '0;
    a_r = '0; b_r = '0; ci_r = 1'b0; op_r = 1'b0;

    #2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset busy d%0d", digit_of[i]), int'(busy_w[i]), 0);
      check($sformatf("reset done d%0d", digit_of[i]), int'(done_w[i]), 0);
      check($sformatf("reset S d%0d", digit_of[i]), int'(s_w[i]), 0);
      check($sformatf("reset CV d%0d", digit_of[i]), int'({c_w[i], v_w[i]}), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table on every DIGIT.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        run_op(i, vecs[j].a, vecs[j].b, vecs[j].ci, vecs[j].op,
               vecs[j].s, vecs[j].c, vecs[j].v);
      end
    end

    // Start while busy is ignored; inputs wander mid-run.
    a_r = 8'h10; b_r = 8'h20; ci_r = 1'b0; op_r = 1'b0;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    ndone = 0;
    first = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 3) begin
        start_r[0] = 1'b1; a_r = 8'hFF; b_r = 8'hFF; ci_r = 1'b1; op_r = 1'b1;
      end else if (cyc == 4) begin
        start_r[0] = 1'b0; a_r = 8'h55; b_r = 8'hAA;
      end
      @(posedge clk); #1;
      if (done_w[0]) begin
        ndone++;
        first = cyc;
      end
    end
    check("ignored_start done_count", ndone, 1);
    check("ignored_start done_cycle", first, 8);
    check("ignored_start S", int'(s_w[0]), 'h30);
    check("ignored_start C", int'(c_w[0]), 0);
    check("ignored_start V", int'(v_w[0]), 0);

    // Start during the done cycle is accepted.
    a_r = 8'h01; b_r = 8'h02; ci_r = 1'b0; op_r = 1'b0;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    check("b2b done_not_repeated", int'(done_w[0]), 0);
    check("b2b busy", int'(busy_w[0]), 1);
    first = 0;
    while (!done_w[0] && first < 20) begin
      @(posedge clk); #1;
      first++;
    end
    check("b2b latency", first, 8);
    check("b2b S", int'(s_w[0]), 'h03);

    // Load C=1, V=1 so the reset clear is visible on every output.
    run_op(0, 8'h80, 8'h81, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1);

    // Reset mid-run.
    a_r = 8'h5A; b_r = 8'h33; ci_r = 1'b0; op_r = 1'b0;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy_w[0]), 0);
    check("abort done", int'(done_w[0]), 0);
    check("abort S", int'(s_w[0]), 0);
    check("abort C", int'(c_w[0]), 0);
    check("abort V", int'(v_w[0]), 0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_w[0]) ndone++;
    end
    check("abort no_done", ndone, 0);
    rst_n = 1'b1;
    run_op(0, 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    // Random sweep against the integer model for DIGIT 1, 2, 8.
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (k == 2) ? 3 : k;
      for (int n = 0; n < 12; n++) begin
        ra  = 8'($urandom_range(0, 255));
        rb  = 8'($urandom_range(0, 255));
        rci = 1'($urandom_range(0, 1));
        rop = 1'($urandom_range(0, 1));
        model(ra, rb, rci, rop, es, ec, ev);
        run_op(idx, ra, rb, rci, rop, es, ec, ev);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
